// File: rtl/fp_norm_round_if.sv
// Handshake and payload bundle for the normalize-and-round stage.
// The slave view is the stage itself; the master view drives it and takes its results.
interface fp_norm_round_if #(
  parameter int unsigned EXP_W  = 5,
  parameter int unsigned FRAC_W = 5
);
  logic                    s_valid;
  logic                    s_ready;
  logic                    s_sign;
  logic [EXP_W-1:0]        s_exp;
  logic [FRAC_W+1:0]       s_sum;
  logic                    s_grd;
  logic                    s_stk;
  logic [2:0]              s_shamt;
  logic                    m_valid;
  logic                    m_ready;
  logic [EXP_W+FRAC_W:0]   m_data;
  logic                    m_ovf;
  logic                    m_uflw;

  modport master (
    output s_valid, s_sign, s_exp, s_sum, s_grd, s_stk, s_shamt, m_ready,
    input  s_ready, m_valid, m_data, m_ovf, m_uflw
  );

  modport slave (
    input  s_valid, s_sign, s_exp, s_sum, s_grd, s_stk, s_shamt, m_ready,
    output s_ready, m_valid, m_data, m_ovf, m_uflw
  );
endinterface

// File: rtl/fp_norm_round.sv
// Two-stage normalize and round-to-nearest-even stage for the adder datapath.
// Stage 1 normalizes the raw sum; stage 2 rounds, saturates and holds the result under backpressure.
module fp_norm_round #(
  parameter int unsigned EXP_W  = 5,
  parameter int unsigned FRAC_W = 5
) (
  input logic            clk,
  input logic            rst_n,
  fp_norm_round_if.slave bus
);

  localparam int unsigned SigW  = FRAC_W + 1;
  localparam int unsigned ExpIW = EXP_W + 2;
  localparam int unsigned DataW = 1 + EXP_W + FRAC_W;
  localparam logic [2:0]       MaxSh  = 3'(FRAC_W);
  localparam logic [ExpIW-1:0] ExpMax = ExpIW'({EXP_W{1'b1}});

  // Stage 1 next-state
  logic [2:0]       k;
  logic [SigW:0]    shifted;
  logic [SigW-1:0]  n_sig;
  logic [ExpIW-1:0] n_exp;
  logic             n_g, n_s, n_zero, n_flush;

  always_comb begin
    k       = (bus.s_shamt > MaxSh) ? MaxSh : bus.s_shamt;
    shifted = {bus.s_sum[SigW-1:0], bus.s_grd} << k;
    n_sig   = bus.s_sum[SigW-1:0];
    n_g     = bus.s_grd;
    n_s     = bus.s_stk;
    n_exp   = ExpIW'(bus.s_exp);
    n_zero  = 1'b0;
    n_flush = 1'b0;
    if (bus.s_sum[SigW]) begin
      n_sig = bus.s_sum[SigW:1];
      n_g   = bus.s_sum[0];
      n_s   = bus.s_grd | bus.s_stk;
      n_exp = ExpIW'(bus.s_exp) + ExpIW'(1);
    end else if (bus.s_sum[SigW-1:0] == '0 && !bus.s_grd) begin
      n_zero = 1'b1;
    end else begin
      n_sig   = shifted[SigW:1];
      n_g     = shifted[0];
      n_exp   = ExpIW'(bus.s_exp) - ExpIW'(k);
      n_flush = (ExpIW'(bus.s_exp) <= ExpIW'(k));
    end
  end

  // Stage 1 registers
  logic             v1_q, v2_q;
  logic             sign1_q, g1_q, s1_q, zero1_q, flush1_q;
  logic [SigW-1:0]  sig1_q;
  logic [ExpIW-1:0] exp1_q;

  logic s1_adv, s1_load;
  assign s1_adv        = v1_q & (!v2_q | bus.m_ready);
  assign bus.s_ready   = rst_n & (!v1_q | s1_adv);
  assign s1_load       = bus.s_valid & bus.s_ready;

  always_ff @(posedge clk) begin
    if (s1_load) begin
      sign1_q  <= bus.s_sign;
      sig1_q   <= n_sig;
      exp1_q   <= n_exp;
      g1_q     <= n_g;
      s1_q     <= n_s;
      zero1_q  <= n_zero;
      flush1_q <= n_flush;
    end
  end

  // Stage 2 rounding
  logic             inc;
  logic [SigW:0]    rnd;
  logic [SigW-1:0]  r_sig;
  logic [ExpIW-1:0] r_exp;
  logic [DataW-1:0] data_d;
  logic             ovf_d, uflw_d;

  always_comb begin
    inc    = g1_q & (s1_q | sig1_q[0]);
    rnd    = {1'b0, sig1_q} + {{SigW{1'b0}}, inc};
    r_sig  = rnd[SigW-1:0];
    r_exp  = exp1_q;
    if (rnd[SigW]) begin
      r_sig = {1'b1, {FRAC_W{1'b0}}};
      r_exp = exp1_q + ExpIW'(1);
    end
    data_d = {sign1_q, r_exp[EXP_W-1:0], r_sig[FRAC_W-1:0]};
    ovf_d  = 1'b0;
    uflw_d = 1'b0;
    if (zero1_q || flush1_q) begin
      data_d = {sign1_q, {(EXP_W + FRAC_W){1'b0}}};
      uflw_d = flush1_q;
    end else if (r_exp >= ExpMax) begin
      data_d = {sign1_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      ovf_d  = 1'b1;
    end
  end

  logic [DataW-1:0] data_q;
  logic             ovf_q, uflw_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      data_q <= '0;
      ovf_q  <= 1'b0;
      uflw_q <= 1'b0;
    end else begin
      if (s1_load) begin
        v1_q <= 1'b1;
      end else if (s1_adv) begin
        v1_q <= 1'b0;
      end
      // Output registers only change when a new beat lands, so they hold under backpressure.
      if (s1_adv) begin
        v2_q   <= 1'b1;
        data_q <= data_d;
        ovf_q  <= ovf_d;
        uflw_q <= uflw_d;
      end else if (bus.m_ready) begin
        v2_q <= 1'b0;
      end
    end
  end

  assign bus.m_valid = v2_q;
  assign bus.m_data  = data_q;
  assign bus.m_ovf   = ovf_q;
  assign bus.m_uflw  = uflw_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Bench for fp_norm_round: arithmetic reference model with an in-order scoreboard,
// plus directed vectors with literal expectations.
module tb_fp_norm_round;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_norm_round_if #(.EXP_W(5), .FRAC_W(5)) bus ();

  fp_norm_round #(.EXP_W(5), .FRAC_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int nvec = 0;
  int nerr = 0;
  int n_out = 0;
  logic [12:0] exp_q [$];
  logic        hold_v = 1'b0;
  logic [12:0] hold_d;
  logic [12:0] got, want;

  // Result as {ovf, uflw, sign, exp[4:0], frac[4:0]}, derived by scaled-integer division with ties to even.
  function automatic logic [12:0] model(input logic sg, input logic [4:0] ex, input logic [6:0] sm,
                                        input logic gd, input logic sk, input logic [2:0] sh);
    int x, q, r, e, kk, v;
    bit up;
    if (sm[6]) begin
      x  = int'(sm) * 4 + int'(gd) * 2 + int'(sk);
      q  = x / 8;
      r  = x % 8;
      up = (r > 4) || (r == 4 && (q % 2) == 1);
      e  = int'(ex) + 1;
    end else if (sm[5:0] == 6'd0 && !gd) begin
      return {2'b00, sg, 10'd0};
    end else begin
      kk = (sh > 3'd5) ? 5 : int'(sh);
      if (int'(ex) <= kk) return {2'b01, sg, 10'd0};
      v  = ((int'(sm[5:0]) * 2 + int'(gd)) << kk) % 128;
      x  = v * 2 + int'(sk);
      q  = x / 4;
      r  = x % 4;
      up = (r > 2) || (r == 2 && (q % 2) == 1);
      e  = int'(ex) - kk;
    end
    q = q + int'(up);
    if (q == 64) begin
      q = 32;
      e = e + 1;
    end
    if (e >= 31) return {2'b10, sg, 5'h1f, 5'h00};
    return {2'b00, sg, e[4:0], q[4:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic drive(input logic sg, input logic [4:0] ex, input logic [6:0] sm,
                       input logic gd, input logic sk, input logic [2:0] sh);
    bus.s_sign  = sg;
    bus.s_exp   = ex;
    bus.s_sum   = sm;
    bus.s_grd   = gd;
    bus.s_stk   = sk;
    bus.s_shamt = sh;
  endtask

  // Scoreboard: samples handshakes half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      got = {bus.m_ovf, bus.m_uflw, bus.m_data};
      if (hold_v) begin
        check("hold valid", 32'(bus.m_valid), 32'd1);
        check("hold data", 32'(got), 32'(hold_d));
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected beat: got %0h, want no beat", got);
        end else begin
          want = exp_q.pop_front();
          check("result", 32'(got), 32'(want));
          n_out++;
        end
      end
      hold_v = bus.m_valid && !bus.m_ready;
      hold_d = got;
      if (bus.s_valid && bus.s_ready)
        exp_q.push_back(model(bus.s_sign, bus.s_exp, bus.s_sum, bus.s_grd, bus.s_stk, bus.s_shamt));
    end
  end

  task automatic one(input string name, input logic sg, input logic [4:0] ex, input logic [6:0] sm,
                     input logic gd, input logic sk, input logic [2:0] sh, input logic [12:0] lit);
    check({name, " model"}, 32'(model(sg, ex, sm, gd, sk, sh)), 32'(lit));
    @(posedge clk); #1;
    drive(sg, ex, sm, gd, sk, sh);
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b1;
    @(negedge clk);
    check({name, " accept"}, 32'(bus.s_ready), 32'd1);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    @(negedge clk);
    check({name, " early"}, 32'(bus.m_valid), 32'd0);
    @(negedge clk);
    check({name, " valid"}, 32'(bus.m_valid), 32'd1);
    check({name, " out"}, 32'({bus.m_ovf, bus.m_uflw, bus.m_data}), 32'(lit));
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, base;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    drive(1'b0, 5'd0, 7'd0, 1'b0, 1'b0, 3'd0);
    repeat (2) @(negedge clk);
    check("reset m_valid", 32'(bus.m_valid), 32'd0);
    check("reset s_ready", 32'(bus.s_ready), 32'd0);
    check("reset m_data", 32'({bus.m_ovf, bus.m_uflw, bus.m_data}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    one("plain",     1'b0, 5'd16, 7'b0100000, 1'b0, 1'b0, 3'd0, 13'h0200);
    one("carry tie", 1'b0, 5'd16, 7'b1000001, 1'b0, 1'b0, 3'd0, 13'h0220);
    one("left norm", 1'b0, 5'd10, 7'b0000101, 1'b0, 1'b0, 3'd3, 13'h00E8);
    one("flush",     1'b1, 5'd2,  7'b0000101, 1'b0, 1'b0, 3'd3, 13'h0C00);
    one("overflow",  1'b0, 5'd30, 7'b1111111, 1'b1, 1'b0, 3'd0, 13'h13E0);
    one("illegal sh",1'b0, 5'd20, 7'b0000001, 1'b0, 1'b0, 3'd7, 13'h01E0);
    one("round up",  1'b0, 5'd16, 7'b0100001, 1'b1, 1'b0, 3'd0, 13'h0202);
    one("tie even",  1'b0, 5'd16, 7'b0100010, 1'b1, 1'b0, 3'd0, 13'h0202);
    one("zero",      1'b1, 5'd9,  7'b0000000, 1'b0, 1'b1, 3'd2, 13'h0400);
    drain();

    // Backpressure: 4 beats, m_ready held low for the first 3 cycles.
    base = n_out;
    acc  = 0;
    for (int c = 0; c < 40 && acc < 4; c++) begin
      @(posedge clk); #1;
      bus.m_ready = (c >= 3);
      drive(acc[0], 5'(12 + acc), 7'(7'b0100000 + 7'(acc * 5)), acc[1], 1'b0, 3'd0);
      bus.s_valid = 1'b1;
      @(negedge clk);
      if (c == 2) check("s_ready full", 32'(bus.s_ready), 32'd0);
      if (bus.s_valid && bus.s_ready) acc++;
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    drain();
    check("bp beat count", 32'(n_out - base), 32'd4);

    // Throughput: back-to-back beats under continuous m_ready.
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      drive(1'($urandom), 5'($urandom_range(1, 31)), 7'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom));
      bus.s_valid = 1'b1;
      @(negedge clk);
      if (bus.s_ready) acc++;
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    check("no bubble", 32'(acc), 32'd8);
    drain();

    // Random traffic with random backpressure.
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      drive(1'($urandom), 5'($urandom), 7'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
      bus.s_valid = 1'($urandom_range(0, 3) != 0);
      bus.m_ready = 1'($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    drain();

    // Reset with two beats in flight.
    bus.m_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      drive(1'b0, 5'd16, 7'b0110000, 1'b0, 1'b0, 3'd0);
      bus.s_valid = 1'b1;
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("s_ready in reset", 32'(bus.s_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    @(negedge clk);
    check("post reset m_valid", 32'(bus.m_valid), 32'd0);
    check("post reset s_ready", 32'(bus.s_ready), 32'd1);
    check("post reset m_data", 32'({bus.m_ovf, bus.m_uflw, bus.m_data}), 32'd0);
    base = n_out;
    repeat (6) @(negedge clk);
    check("discarded beats", 32'(n_out - base), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
